// File: rtl/snake_engine.sv
// snake_engine: variable-length snake on a cell grid. Advances one cell per step tick,
// filters direction keys, grows on food, detects self/wall collision, answers pixel queries.
module snake_engine #(
   parameter int XW       = 10,
   parameter int YW       = 10,
   parameter int X_MAX    = 799,
   parameter int Y_MAX    = 599,
   parameter int MAX_LEN  = 16,
   parameter int INIT_LEN = 3,
   parameter int INIT_X   = 400,
   parameter int INIT_Y   = 300,
   parameter int STEP_DIV = 312500,
   parameter int WRAP     = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           pause,
   input  logic [3:0]                     dir_req,
   input  logic [XW-1:0]                  food_x,
   input  logic [YW-1:0]                  food_y,
   input  logic [XW-1:0]                  pix_x,
   input  logic [YW-1:0]                  pix_y,
   output logic [XW-1:0]                  head_x,
   output logic [YW-1:0]                  head_y,
   output logic [$clog2(MAX_LEN+1)-1:0]   length,
   output logic                           step,
   output logic                           eat,
   output logic                           fin,
   output logic [1:0]                     state,
   output logic                           snake_pix,
   output logic                           head_pix
);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [XW-1:0] X_LAST   = XW'(X_MAX);
   localparam logic [YW-1:0] Y_LAST   = YW'(Y_MAX);
   localparam logic [XW-1:0] X_ONE    = XW'(1);
   localparam logic [YW-1:0] Y_ONE    = YW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
   localparam logic [LW-1:0] LEN_INIT = LW'(INIT_LEN);
   localparam logic [LW-1:0] LEN_ONE  = LW'(1);
   localparam logic          WRAP_EN  = (WRAP != 32'sd0);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DEAD = 2'd2} state_t;
   typedef enum logic [1:0] {DIR_RIGHT = 2'd0, DIR_LEFT = 2'd1, DIR_UP = 2'd2, DIR_DOWN = 2'd3} dir_t;

   function automatic dir_t opposite(input dir_t d);
      case (d)
         DIR_RIGHT: opposite = DIR_LEFT;
         DIR_LEFT:  opposite = DIR_RIGHT;
         DIR_UP:    opposite = DIR_DOWN;
         DIR_DOWN:  opposite = DIR_UP;
         default:   opposite = DIR_LEFT;
      endcase
   endfunction

   function automatic logic [XW-1:0] init_x(input int i);
      if (i < INIT_LEN) init_x = XW'(INIT_X - i);
      else              init_x = {XW{1'b0}};
   endfunction

   function automatic logic [YW-1:0] init_y(input int i);
      if (i < INIT_LEN) init_y = YW'(INIT_Y);
      else              init_y = {YW{1'b0}};
   endfunction

   state_t          state_r, state_nx_s;
   dir_t            dir_r, cur_dir_r, req_dir_s;
   logic [CW-1:0]   cnt_r, cnt_nx_s;
   logic [XW-1:0]   seg_x_r [MAX_LEN];
   logic [YW-1:0]   seg_y_r [MAX_LEN];
   logic [LW-1:0]   len_r;
   logic [XW-1:0]   nx_s;
   logic [YW-1:0]   ny_s;
   logic            req_vld_s, accept_s, edge_s, off_s, food_s, grow_s, hit_s;
   logic            due_s, die_s, adv_s, reinit_s;
   logic            step_r, eat_r, fin_r;

   // Key priority right>left>up>down; reversal against the last stepped direction is dropped.
   always_comb begin
      req_vld_s = 1'b1;
      req_dir_s = DIR_RIGHT;
      if (dir_req[0])      req_dir_s = DIR_RIGHT;
      else if (dir_req[1]) req_dir_s = DIR_LEFT;
      else if (dir_req[2]) req_dir_s = DIR_UP;
      else if (dir_req[3]) req_dir_s = DIR_DOWN;
      else                 req_vld_s = 1'b0;
      accept_s = req_vld_s && (state_r != ST_DEAD) && (req_dir_s != opposite(cur_dir_r));
   end

   // Next head cell, edge handling, food match and collision against the cells that stay.
   always_comb begin
      nx_s   = seg_x_r[0];
      ny_s   = seg_y_r[0];
      edge_s = 1'b0;
      case (dir_r)
         DIR_RIGHT: if (seg_x_r[0] == X_LAST) begin nx_s = {XW{1'b0}}; edge_s = 1'b1; end
                    else nx_s = seg_x_r[0] + X_ONE;
         DIR_LEFT:  if (seg_x_r[0] == {XW{1'b0}}) begin nx_s = X_LAST; edge_s = 1'b1; end
                    else nx_s = seg_x_r[0] - X_ONE;
         DIR_UP:    if (seg_y_r[0] == {YW{1'b0}}) begin ny_s = Y_LAST; edge_s = 1'b1; end
                    else ny_s = seg_y_r[0] - Y_ONE;
         DIR_DOWN:  if (seg_y_r[0] == Y_LAST) begin ny_s = {YW{1'b0}}; edge_s = 1'b1; end
                    else ny_s = seg_y_r[0] + Y_ONE;
         default:   edge_s = 1'b0;
      endcase
      off_s  = edge_s && !WRAP_EN;
      food_s = (nx_s == food_x) && (ny_s == food_y);
      grow_s = food_s && (len_r < LEN_MAX);
      hit_s  = 1'b0;
      // The tail only counts when growing, because otherwise it vacates its cell this step.
      for (int i = 0; i < MAX_LEN; i++) begin
         hit_s = hit_s | (((LW'(i) < len_r - LEN_ONE) || (grow_s && (LW'(i) == len_r - LEN_ONE)))
                          && (seg_x_r[i] == nx_s) && (seg_y_r[i] == ny_s));
      end
      due_s    = (state_r == ST_RUN) && !pause && (cnt_r == CNT_LAST);
      die_s    = due_s && (off_s || hit_s);
      adv_s    = due_s && !die_s;
      reinit_s = (state_r == ST_DEAD) && start;
   end

   // FSM next state and step-tick counter.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            cnt_nx_s = {CW{1'b0}};
            if (start) state_nx_s = ST_RUN;
            else       state_nx_s = ST_IDLE;
         end
         ST_RUN: begin
            if (die_s) state_nx_s = ST_DEAD;
            else       state_nx_s = ST_RUN;
            if (due_s)      cnt_nx_s = {CW{1'b0}};
            else if (pause) cnt_nx_s = cnt_r;
            else            cnt_nx_s = cnt_r + CNT_ONE;
         end
         ST_DEAD: begin
            cnt_nx_s = {CW{1'b0}};
            if (start) state_nx_s = ST_RUN;
            else       state_nx_s = ST_DEAD;
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = {CW{1'b0}};
         end
      endcase
   end

   // Control registers: state, counter, directions and the output pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= {CW{1'b0}};
         dir_r     <= DIR_RIGHT;
         cur_dir_r <= DIR_RIGHT;
         step_r    <= 1'b0;
         eat_r     <= 1'b0;
         fin_r     <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         step_r  <= adv_s;
         eat_r   <= adv_s && food_s;
         fin_r   <= (state_nx_s == ST_DEAD);
         if (reinit_s) begin
            dir_r     <= DIR_RIGHT;
            cur_dir_r <= DIR_RIGHT;
         end else begin
            if (accept_s) dir_r     <= req_dir_s;
            if (adv_s)    cur_dir_r <= dir_r;
         end
      end
   end

   // Body storage: unused slots keep their (0,0) value since only active slots shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_r <= LEN_INIT;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_r[i] <= init_x(i);
            seg_y_r[i] <= init_y(i);
         end
      end else if (reinit_s) begin
         len_r <= LEN_INIT;
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x_r[i] <= init_x(i);
            seg_y_r[i] <= init_y(i);
         end
      end else if (adv_s) begin
         seg_x_r[0] <= nx_s;
         seg_y_r[0] <= ny_s;
         for (int i = 1; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_r) || (grow_s && (LW'(i) == len_r))) begin
               seg_x_r[i] <= seg_x_r[i-1];
               seg_y_r[i] <= seg_y_r[i-1];
            end
         end
         if (grow_s) len_r <= len_r + LEN_ONE;
      end
   end

   // Zero-latency render query over the active segments.
   always_comb begin
      snake_pix = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         snake_pix = snake_pix | ((LW'(i) < len_r) && (seg_x_r[i] == pix_x) && (seg_y_r[i] == pix_y));
      end
      head_pix = (seg_x_r[0] == pix_x) && (seg_y_r[0] == pix_y);
   end

   assign head_x = seg_x_r[0];
   assign head_y = seg_y_r[0];
   assign length = len_r;
   assign step   = step_r;
   assign eat    = eat_r;
   assign fin    = fin_r;
   assign state  = state_r;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: one wrapping and one wall-killing instance share the stimulus;
// a queue-based model of each snake is checked every cycle, plus literal spot checks.
module tb_snake_engine;
   localparam int XW = 5, YW = 5, XM = 15, YM = 11, ML = 6, IL = 3, IX = 8, IY = 5, SD = 4;
   localparam int LW = $clog2(ML + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, pause = 1'b0;
   logic [3:0] dir_req = 4'd0;
   logic [XW-1:0] food_x = 5'd3, pix_x = 5'd0;
   logic [YW-1:0] food_y = 5'd9, pix_y = 5'd0;

   logic [XW-1:0] o_hx [2];
   logic [YW-1:0] o_hy [2];
   logic [LW-1:0] o_len [2];
   logic [1:0]    o_st [2];
   logic          o_step [2], o_eat [2], o_fin [2], o_spix [2], o_hpix [2];

   int total = 0, bad = 0;
   bit chk_en = 1'b0;

   // model: body[k][0] is the head, coordinates packed as x*64+y
   int body [2][$];
   int mstate [2], mcnt [2], mdir [2], mcur [2];
   bit mstep [2], meat [2];

   always #5 clk = ~clk;

   snake_engine #(.XW(XW), .YW(YW), .X_MAX(XM), .Y_MAX(YM), .MAX_LEN(ML), .INIT_LEN(IL),
                  .INIT_X(IX), .INIT_Y(IY), .STEP_DIV(SD), .WRAP(1)) u_wrap (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .dir_req(dir_req),
      .food_x(food_x), .food_y(food_y), .pix_x(pix_x), .pix_y(pix_y),
      .head_x(o_hx[0]), .head_y(o_hy[0]), .length(o_len[0]), .step(o_step[0]), .eat(o_eat[0]),
      .fin(o_fin[0]), .state(o_st[0]), .snake_pix(o_spix[0]), .head_pix(o_hpix[0]));

   snake_engine #(.XW(XW), .YW(YW), .X_MAX(XM), .Y_MAX(YM), .MAX_LEN(ML), .INIT_LEN(IL),
                  .INIT_X(IX), .INIT_Y(IY), .STEP_DIV(SD), .WRAP(0)) u_nowrap (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .dir_req(dir_req),
      .food_x(food_x), .food_y(food_y), .pix_x(pix_x), .pix_y(pix_y),
      .head_x(o_hx[1]), .head_y(o_hy[1]), .length(o_len[1]), .step(o_step[1]), .eat(o_eat[1]),
      .fin(o_fin[1]), .state(o_st[1]), .snake_pix(o_spix[1]), .head_pix(o_hpix[1]));

   function automatic int opposite(input int d);
      case (d)
         0: opposite = 1;
         1: opposite = 0;
         2: opposite = 3;
         default: opposite = 2;
      endcase
   endfunction

   task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL u%0d %s: got %0d, expected %0d", k, nm, act, exp);
      end
   endtask

   task automatic model_init(input int k);
      body[k].delete();
      for (int i = 0; i < IL; i++) body[k].push_back((IX - i) * 64 + IY);
      mdir[k] = 0; mcur[k] = 0; mcnt[k] = 0; mstep[k] = 1'b0; meat[k] = 1'b0;
   endtask

   task automatic model_clock(input int k, input bit wrap);
      int req, old_dir, old_cur, nx, ny;
      bit out, hit, food, grow;
      old_dir = mdir[k]; old_cur = mcur[k];
      mstep[k] = 1'b0; meat[k] = 1'b0;
      req = -1;
      if (dir_req[0]) req = 0;
      else if (dir_req[1]) req = 1;
      else if (dir_req[2]) req = 2;
      else if (dir_req[3]) req = 3;
      if (mstate[k] != 2 && req >= 0 && req != opposite(old_cur)) mdir[k] = req;
      case (mstate[k])
         0: if (start) begin mstate[k] = 1; mcnt[k] = 0; end
         1: if (!pause) begin
            if (mcnt[k] == SD - 1) begin
               mcnt[k] = 0;
               nx = body[k][0] / 64; ny = body[k][0] % 64; out = 1'b0;
               case (old_dir)
                  0: nx = nx + 1;
                  1: nx = nx - 1;
                  2: ny = ny - 1;
                  default: ny = ny + 1;
               endcase
               if (nx > XM || nx < 0 || ny > YM || ny < 0) begin
                  if (wrap) begin nx = (nx + XM + 1) % (XM + 1); ny = (ny + YM + 1) % (YM + 1); end
                  else out = 1'b1;
               end
               food = (nx == int'(food_x)) && (ny == int'(food_y));
               grow = food && (body[k].size() < ML);
               hit = 1'b0;
               for (int i = 0; i < body[k].size(); i++)
                  if (body[k][i] == nx * 64 + ny && (i < body[k].size() - 1 || grow)) hit = 1'b1;
               if (out || hit) mstate[k] = 2;
               else begin
                  body[k].push_front(nx * 64 + ny);
                  if (!grow) void'(body[k].pop_back());
                  mcur[k] = old_dir; mstep[k] = 1'b1; meat[k] = food;
               end
            end else mcnt[k]++;
         end
         default: if (start) begin model_init(k); mstate[k] = 1; end
      endcase
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin model_init(k); mstate[k] = 0; end
      forever begin
         @(posedge clk or posedge rst);
         if (rst) for (int k = 0; k < 2; k++) begin model_init(k); mstate[k] = 0; end
         else begin model_clock(0, 1'b1); model_clock(1, 1'b0); end
      end
   end

   // render query sweep: rows 5,4,0,5 across all columns
   initial begin
      int cyc;
      cyc = 0;
      forever begin
         @(posedge clk); #2;
         pix_x = XW'(cyc % 16);
         case ((cyc / 16) % 4)
            0: pix_y = 5'd5;
            1: pix_y = 5'd4;
            2: pix_y = 5'd0;
            default: pix_y = 5'd5;
         endcase
         cyc++;
      end
   end

   // per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
               int es;
               es = 0;
               for (int i = 0; i < body[k].size(); i++)
                  if (body[k][i] == int'(pix_x) * 64 + int'(pix_y)) es = 1;
               chk(k, "head_x", o_hx[k], body[k][0] / 64);
               chk(k, "head_y", o_hy[k], body[k][0] % 64);
               chk(k, "length", o_len[k], body[k].size());
               chk(k, "state", o_st[k], mstate[k]);
               chk(k, "step", o_step[k], mstep[k]);
               chk(k, "eat", o_eat[k], meat[k]);
               chk(k, "fin", o_fin[k], (mstate[k] == 2) ? 1 : 0);
               chk(k, "snake_pix", o_spix[k], es);
               chk(k, "head_pix", o_hpix[k], (body[k][0] == int'(pix_x) * 64 + int'(pix_y)) ? 1 : 0);
            end
         end
      end
   end

   task automatic wait_step(input int k);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (mstep[k]) return;
      end
      total++; bad++;
      $display("FAIL u%0d wait_step: got no step in 40 cycles, expected one", k);
   endtask

   task automatic wait_dead(input int k);
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (mstate[k] == 2) return;
      end
      total++; bad++;
      $display("FAIL u%0d wait_dead: got state %0d after 40 cycles, expected 2", k, mstate[k]);
   endtask

   task automatic keys(input logic [3:0] v1, input logic [3:0] v2);
      @(posedge clk); #2 dir_req = v1;
      @(posedge clk); #2 dir_req = v2;
      @(posedge clk); #2 dir_req = 4'd0;
   endtask

   task automatic set_food(input int x, input int y);
      @(posedge clk); #2;
      food_x = XW'(x); food_y = YW'(y);
   endtask

   task automatic pulse_start();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish by 100000, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      #2 rst = 1'b0; chk_en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk(k, "rst_state", o_st[k], 0);
         chk(k, "rst_head_x", o_hx[k], 8);
         chk(k, "rst_len", o_len[k], 3);
         chk(k, "rst_fin", o_fin[k], 0);
      end
      // start with food two cells ahead
      @(posedge clk); #2 start = 1'b1; food_x = 5'd10; food_y = 5'd5;
      @(posedge clk); #2 start = 1'b0;
      wait_step(0);
      chk(0, "step1_head_x", o_hx[0], 9);
      chk(0, "step1_len", o_len[0], 3);
      wait_step(0);
      chk(0, "eat1_head_x", o_hx[0], 10);
      chk(0, "eat1_eat", o_eat[0], 1);
      chk(0, "eat1_len", o_len[0], 4);
      chk(0, "eat1_model_tail", body[0][3], 7 * 64 + 5);
      set_food(12, 5);
      wait_step(0); wait_step(0);
      chk(0, "eat2_len", o_len[0], 5);
      set_food(14, 5);
      wait_step(0); wait_step(0);
      chk(0, "eat3_len", o_len[0], 6);
      wait_step(0);
      chk(0, "edge_head_x", o_hx[0], 15);
      set_food(1, 5);
      wait_step(0);
      chk(0, "wrap_head_x", o_hx[0], 0);
      chk(1, "wall_state", o_st[1], 2);
      chk(1, "wall_fin", o_fin[1], 1);
      chk(1, "wall_head_x", o_hx[1], 15);
      wait_step(0);
      chk(0, "sat_eat", o_eat[0], 1);
      chk(0, "sat_len", o_len[0], 6);
      set_food(7, 9);
      // reversal alone is ignored
      keys(4'b0010, 4'b0000);
      wait_step(0);
      chk(0, "rev_head_x", o_hx[0], 2);
      chk(0, "rev_head_y", o_hy[0], 5);
      // up then left in one period: up wins
      keys(4'b0100, 4'b0010);
      wait_step(0);
      chk(0, "up_head_x", o_hx[0], 2);
      chk(0, "up_head_y", o_hy[0], 4);
      keys(4'b0010, 4'b0000);
      wait_step(0);
      keys(4'b1000, 4'b0000);
      wait_dead(0);
      chk(0, "self_state", o_st[0], 2);
      chk(0, "self_fin", o_fin[0], 1);
      chk(0, "self_head_x", o_hx[0], 1);
      chk(0, "self_head_y", o_hy[0], 4);
      pulse_start();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk(k, "restart_state", o_st[k], 1);
         chk(k, "restart_head_x", o_hx[k], 8);
         chk(k, "restart_len", o_len[k], 3);
         chk(k, "restart_fin", o_fin[k], 0);
      end
      wait_step(0);
      @(posedge clk); #2 pause = 1'b1;
      repeat (10) @(posedge clk);
      #2 pause = 1'b0;
      @(negedge clk);
      chk(0, "pause_head_x", o_hx[0], 9);
      wait_step(0);
      chk(0, "resume_head_x", o_hx[0], 10);
      // asynchronous reset mid-run
      @(posedge clk); #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk(k, "arst_state", o_st[k], 0);
         chk(k, "arst_head_x", o_hx[k], 8);
         chk(k, "arst_len", o_len[k], 3);
         chk(k, "arst_step", o_step[k], 0);
         chk(k, "arst_fin", o_fin[k], 0);
      end
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
